// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parameter limits and a
// constant-evaluable clog2 helper used for counter sizing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rxState_e;

    localparam int MIN_OVERSAMPLE = 8;
    localparam int MIN_DATA_BITS  = 5;
    localparam int MAX_DATA_BITS  = 9;
    localparam int MIN_STOP_BITS  = 1;
    localparam int MAX_STOP_BITS  = 2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running fractional accumulator whose carry
// out is the tick, giving BAUD*OVERSAMPLE ticks per second on average.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int ACC_W = clog2(CLK_FREQ / BAUD) + 8;
    localparam longint unsigned TICK_RATE = longint'(BAUD) * longint'(OVERSAMPLE);
    localparam longint unsigned INC_WIDE  =
        ((TICK_RATE << ACC_W) + longint'(CLK_FREQ / 2)) / longint'(CLK_FREQ);
    // One extra bit: when the tick rate equals the clock the increment is 2**ACC_W.
    localparam logic [ACC_W:0] INC = (ACC_W + 1)'(INC_WIDE);

    if (CLK_FREQ < BAUD * OVERSAMPLE) begin : gBadClock
        $error("uart_baud_tick: CLK_FREQ must be at least BAUD*OVERSAMPLE");
    end

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + INC;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            tick <= 1'b0;
        end else begin
            acc  <= sum[ACC_W-1:0];
            tick <= sum[ACC_W];
        end
    end

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver with majority-vote sampling, error/break flags
// and idle detect. Define UART_RX_PARITY_EN to receive and check a parity bit.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int IDLE_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 idle
);

    localparam int PHASE_W  = clog2(OVERSAMPLE);
    localparam int BIT_W    = clog2(DATA_BITS + 1);
    localparam int IDLE_MAX = IDLE_BITS * OVERSAMPLE;
    localparam int IDLE_W   = clog2(IDLE_MAX + 1);
    localparam logic [PHASE_W-1:0] PH_A      = PHASE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PHASE_W-1:0] PH_B      = PHASE_W'(OVERSAMPLE / 2);
    localparam logic [PHASE_W-1:0] PH_C      = PHASE_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic               LAST_STOP = 1'(STOP_BITS - 1);

    if (OVERSAMPLE < MIN_OVERSAMPLE || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : gBadOversample
        $error("uart_rx_framed: OVERSAMPLE must be a power of two of at least 8");
    end
    if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : gBadDataBits
        $error("uart_rx_framed: DATA_BITS out of range");
    end
    if (STOP_BITS < MIN_STOP_BITS || STOP_BITS > MAX_STOP_BITS) begin : gBadStopBits
        $error("uart_rx_framed: STOP_BITS out of range");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1 || IDLE_BITS < 1) begin : gBadMisc
        $error("uart_rx_framed: PARITY_ODD must be 0/1 and IDLE_BITS at least 1");
    end

    logic                 tick;
    logic                 rxdMeta, rxdSync, rxdPrev;
    logic [PHASE_W-1:0]   phase;
    logic                 vote0, vote1, voted;
    logic                 startEdge, samplePoint, firstStop;
    rxState_e             state, nextState;
    logic [BIT_W-1:0]     bitCnt;
    logic                 stopCnt;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 sawOne, stopErr;
    logic                 publish, breakNow, frameErrNow;
    logic [IDLE_W-1:0]    idleCnt;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) uBaudTick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxdMeta <= 1'b1;
            rxdSync <= 1'b1;
            rxdPrev <= 1'b1;
        end else begin
            rxdMeta <= rxd;
            rxdSync <= rxdMeta;
            rxdPrev <= rxdSync;
        end
    end

    assign startEdge   = rxdPrev & ~rxdSync;
    assign samplePoint = tick && (phase == PH_C);
    assign voted       = (vote0 & vote1) | (vote0 & rxdSync) | (vote1 & rxdSync);
    assign firstStop   = (stopCnt == 1'b0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        // NOTE: defaults first on every combinational output so no path infers a latch.
        nextState   = state;
        publish     = 1'b0;
        breakNow    = ~sawOne & ~(firstStop & voted);
        frameErrNow = stopErr | ~voted;
        case (state)
            IDLE:       if (startEdge) nextState = START;
            START:      if (samplePoint) nextState = voted ? IDLE : DATA;
            DATA: begin
                if (samplePoint && bitCnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                    nextState = PARITY;
`else
                    nextState = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY:     if (samplePoint) nextState = STOP;
`endif
            STOP: begin
                if (samplePoint && stopCnt == LAST_STOP) begin
                    publish   = 1'b1;
                    nextState = breakNow ? BREAK_WAIT : IDLE;
                end
            end
            BREAK_WAIT: if (samplePoint && voted) nextState = IDLE;
            default:    nextState = IDLE;
        endcase
    end

    // NOTE: the phase, votes and shift register carry no reset; each is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (state == IDLE && startEdge) phase <= '0;
        else if (tick)                  phase <= phase + PHASE_W'(1);
        if (tick && phase == PH_A) vote0 <= rxdSync;
        if (tick && phase == PH_B) vote1 <= rxdSync;

        if (state == IDLE) begin
            bitCnt  <= '0;
            stopCnt <= 1'b0;
            sawOne  <= 1'b0;
            stopErr <= 1'b0;
        end else if (samplePoint) begin
            if (state == DATA) begin
                shiftReg <= {voted, shiftReg[DATA_BITS-1:1]};
                bitCnt   <= bitCnt + BIT_W'(1);
                sawOne   <= sawOne | voted;
            end
            if (state == PARITY) sawOne <= sawOne | voted;
            if (state == STOP) begin
                stopCnt <= 1'b1;
                stopErr <= frameErrNow;
                if (firstStop) sawOne <= sawOne | voted;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parityAcc;

    // Seeded with PARITY_ODD so a correct frame leaves the accumulator at zero.
    always_ff @(posedge clk) begin
        if (state == IDLE)
            parityAcc <= 1'(PARITY_ODD);
        else if (samplePoint && (state == DATA || state == PARITY))
            parityAcc <= parityAcc ^ voted;

        if (rst)          parity_err <= 1'b0;
        else if (publish) parity_err <= parityAcc;
    end
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            data_valid <= publish;
            if (publish) begin
                data      <= shiftReg;
                frame_err <= frameErrNow;
                break_det <= breakNow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != IDLE)
            idleCnt <= '0;
        else if (tick && idleCnt != IDLE_W'(IDLE_MAX))
            idleCnt <= idleCnt + IDLE_W'(1);
    end

    assign idle = (idleCnt == IDLE_W'(IDLE_MAX));

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed at one tick per clk (16 clk per bit);
// expected characters are queued as frames are driven and checked on data_valid.
`timescale 1ns/1ps
module tb_uart_rx_framed;

    localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bd;
    } expT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       data_valid, parity_err, frame_err, break_det, idle;

    expT expQ[$];
    int  checks = 0;
    int  errors = 0;
    int  cycle = 0;
    int  lastDvCycle = -1000;
    int  prevDvCycle = -1000;
    bit  prevDv = 1'b0;

    uart_rx_framed #(
        .CLK_FREQ  (1600000),
        .BAUD      (100000),
        .OVERSAMPLE(16),
        .DATA_BITS (8),
        .PARITY_ODD(0),
        .STOP_BITS (1),
        .IDLE_BITS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .data      (data),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .break_det (break_det),
        .idle      (idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog timeout");
    end

    // Scoreboard: every data_valid pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (rst) begin
            prevDv = 1'b0;
        end else begin
            if (data_valid) begin
                expT e;
                prevDvCycle = lastDvCycle;
                lastDvCycle = cycle;
                checks++;
                assert (prevDv === 1'b0) else begin
                    errors++;
                    $error("FAIL dv_width got two-cycle pulse want one-cycle at cycle %0d", cycle);
                end
                checks++;
                assert (expQ.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_dv got data %h want no pulse", data);
                end
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checks++;
                    assert (data === e.data) else begin
                        errors++;
                        $error("FAIL data got %h want %h", data, e.data);
                    end
                    checks++;
                    assert ({parity_err, frame_err, break_det} === {e.pe, e.fe, e.bd}) else begin
                        errors++;
                        $error("FAIL flags(pe,fe,bd) got %b want %b",
                               {parity_err, frame_err, break_det}, {e.pe, e.fe, e.bd});
                    end
                end
            end
            prevDv = data_valid;
        end
    end

    task automatic waitClks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A spike pulls the line low for one clk at the bit's first voting sample.
    task automatic sendBit(input logic b, input bit spike);
        for (int c = 0; c < BIT_CLKS; c++) begin
            rxd = (spike && c == 8) ? 1'b0 : b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic parFlip, input logic stopVal,
                             input bit spikes, input bit expectOut);
        expT  e;
        logic parBit;
        parBit = (^d) ^ parFlip;
        e.data = d;
`ifdef UART_RX_PARITY_EN
        e.pe = parFlip;
        e.bd = (d == 8'h00) && !parBit && !stopVal;
`else
        e.pe = 1'b0;
        e.bd = (d == 8'h00) && !stopVal;
`endif
        e.fe = ~stopVal;
        if (expectOut) expQ.push_back(e);
        sendBit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) sendBit(d[i], spikes && d[i]);
`ifdef UART_RX_PARITY_EN
        sendBit(parBit, spikes && parBit);
`endif
        sendBit(stopVal, spikes && stopVal);
        rxd = 1'b1;
    endtask

    initial begin
        int  firstIdle;
        expT e;

        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        assert ({data_valid, parity_err, frame_err, break_det} === 4'b0000) else begin
            errors++;
            $error("FAIL reset_flags got %b want 0000", {data_valid, parity_err, frame_err, break_det});
        end
        checks++;
        assert (data === 8'h00) else begin
            errors++;
            $error("FAIL reset_data got %h want 00", data);
        end
        checks++;
        assert (idle === 1'b0) else begin
            errors++;
            $error("FAIL reset_idle got %b want 0", idle);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        waitClks(3 * BIT_CLKS);

        // Basic frame, then two frames back to back
        sendFrame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
        waitClks(2 * BIT_CLKS);
        sendFrame(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        sendFrame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        assert (lastDvCycle - prevDvCycle === FRAME_BITS * BIT_CLKS) else begin
            errors++;
            $error("FAIL b2b_interval got %0d want %0d", lastDvCycle - prevDvCycle, FRAME_BITS * BIT_CLKS);
        end
        waitClks(2 * BIT_CLKS);

        // Parity good / bad (plain frame when parity is compiled out)
        sendFrame(8'h03, 1'b0, 1'b1, 1'b0, 1'b1);
        waitClks(BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        sendFrame(8'h03, 1'b1, 1'b1, 1'b0, 1'b1);
        waitClks(BIT_CLKS);
`endif

        // Framing error, then data held after the pulse
        sendFrame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        waitClks(3 * BIT_CLKS);
        checks++;
        assert (data === 8'h55) else begin
            errors++;
            $error("FAIL data_hold got %h want 55", data);
        end

        // Break: line low for 20 bit-times, then a fresh frame
        e.data = 8'h00;
        e.pe   = 1'b0;
        e.fe   = 1'b1;
        e.bd   = 1'b1;
        expQ.push_back(e);
        rxd = 1'b0;
        waitClks(20 * BIT_CLKS);
        rxd = 1'b1;
        waitClks(2 * BIT_CLKS);
        sendFrame(8'h81, 1'b0, 1'b1, 1'b0, 1'b1);
        waitClks(3 * BIT_CLKS);

        // Short glitch is a false start; receiver re-arms in time for a frame right after
        checks++;
        assert (idle === 1'b1) else begin
            errors++;
            $error("FAIL idle_before_glitch got %b want 1", idle);
        end
        rxd = 1'b0;
        waitClks(4);
        rxd = 1'b1;
        waitClks(2);
        checks++;
        assert (idle === 1'b0) else begin
            errors++;
            $error("FAIL idle_after_start got %b want 0", idle);
        end
        waitClks(6);
        sendFrame(8'hB7, 1'b0, 1'b1, 1'b1, 1'b1);
        waitClks(2 * BIT_CLKS);

        // Reset mid-byte, then a clean frame and the idle delay after it
        sendBit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sendBit(i[0], 1'b0);
        rst = 1'b1;
        rxd = 1'b1;
        waitClks(4);
        rst = 1'b0;
        waitClks(3 * BIT_CLKS);
        sendFrame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
        firstIdle = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (idle === 1'b1) begin
                firstIdle = cycle;
                break;
            end
        end
        checks++;
        assert (firstIdle - lastDvCycle === 2 * BIT_CLKS) else begin
            errors++;
            $error("FAIL idle_delay got %0d want %0d", firstIdle - lastDvCycle, 2 * BIT_CLKS);
        end
        waitClks(2 * BIT_CLKS);

        checks++;
        assert (expQ.size() === 0) else begin
            errors++;
            $error("FAIL missing_dv got %0d outstanding want 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
